// File: rtl/branch_resolve.sv
// branch_resolve
// Resolves one RV32I-style conditional branch per cycle. It computes the
// direction, the next PC, the misprediction flag and an illegal-encoding flag,
// and registers them behind a one-deep valid/ready output stage. It also keeps
// saturating counts of accepted branches and accepted mispredictions.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/ready   request handshake (funct3, rs1_val, rs2_val, pc, imm,
//                    pred_taken are sampled on acceptance)
//   out_valid/ready  result handshake (taken, target, mispredict, illegal)
//   cnt_clr          synchronous clear of br_count / mis_count
//   br_count         accepted requests (saturating)
//   mis_count        accepted requests that mispredicted (saturating)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready = !out_valid || out_ready, so a new request may be
// accepted in the same cycle that the held result is consumed. Results are
// held unchanged while out_valid && !out_ready.
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic             mispredict,
    output logic             illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic             taken_q, taken_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             mispredict_q, mispredict_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;

    logic             accept;
    logic             res_taken;
    logic             res_illegal;
    logic             res_mispredict;
    logic [XLEN-1:0]  res_target;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Branch condition evaluation over the full operand width.
    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (funct3)
            3'b000:  res_taken = (rs1_val == rs2_val);
            3'b001:  res_taken = (rs1_val != rs2_val);
            3'b100:  res_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  res_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  res_taken = (rs1_val <  rs2_val);
            3'b111:  res_taken = (rs1_val >= rs2_val);
            default: res_illegal = 1'b1;  // 010 / 011: not a branch, fall through
        endcase
        // Additions wrap modulo 2^XLEN by construction of the result width.
        res_target     = res_taken ? (pc + imm) : (pc + PC_STEP);
        res_mispredict = res_taken ^ pred_taken;
    end

    // Output stage and statistics next-state.
    always_comb begin
        out_valid_d  = out_valid_q;
        taken_d      = taken_q;
        target_d     = target_q;
        mispredict_d = mispredict_q;
        illegal_d    = illegal_q;
        br_count_d   = br_count_q;
        mis_count_d  = mis_count_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            taken_d      = res_taken;
            target_d     = res_target;
            mispredict_d = res_mispredict;
            illegal_d    = res_illegal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end

        // Clear wins over a same-cycle increment; the event is dropped.
        if (cnt_clr) begin
            br_count_d  = '0;
            mis_count_d = '0;
        end else if (accept) begin
            if (br_count_q != CNT_MAX) begin
                br_count_d = br_count_q + 1'b1;
            end
            if (res_mispredict && (mis_count_q != CNT_MAX)) begin
                mis_count_d = mis_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            br_count_q   <= '0;
            mis_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            br_count_q   <= br_count_d;
            mis_count_q  <= mis_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign taken      = taken_q;
    assign target     = target_q;
    assign mispredict = mispredict_q;
    assign illegal    = illegal_q;
    assign br_count   = br_count_q;
    assign mis_count  = mis_count_q;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, PC and immediate width; legal range 8..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  the request on the input ports is valid.
REQ-006 SHALL have port in_ready  output  1  the block can accept a request this cycle.
REQ-007 SHALL have port funct3  input  3  branch type (RV32I B-type encoding).
REQ-008 SHALL have port rs1_val  input  XLEN  first operand.
REQ-009 SHALL have port rs2_val  input  XLEN  second operand.
REQ-010 SHALL have port pc  input  XLEN  branch instruction address.
REQ-011 SHALL have port imm  input  XLEN  sign-extended branch offset.
REQ-012 SHALL have port pred_taken  input  1  direction predicted by the front end.
REQ-013 SHALL have port out_valid  output  1  the result register holds an unconsumed result.
REQ-014 SHALL have port out_ready  input  1  the consumer accepts the result this cycle.
REQ-015 SHALL have port taken  output  1  resolved branch direction.
REQ-016 SHALL have port target  output  XLEN  resolved next PC.
REQ-017 SHALL have port mispredict  output  1  taken differs from pred_taken.
REQ-018 SHALL have port illegal  output  1  funct3 was not a branch encoding.
REQ-019 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-020 SHALL have port br_count  output  CNT_W  number of accepted requests.
REQ-021 SHALL have port mis_count  output  CNT_W  number of accepted requests that mispredicted.

Function
REQ-022 SHALL drive in_ready = !out_valid || out_ready (combinational); a request is accepted when in_valid && in_ready.
REQ-023 SHALL register the results of an accepted request into the output register at the next edge and set out_valid=1: latency 1 cycle, throughput 1 per cycle.
REQ-024 SHALL clear out_valid when out_valid && out_ready && no acceptance occurs in the same cycle.
REQ-025 SHALL hold taken, target, mispredict and illegal stable while out_valid=1 && out_ready=0.
REQ-026 SHALL resolve taken per funct3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; comparisons span the full XLEN.
REQ-027 SHALL treat funct3 010 and 011 as illegal: illegal=1, taken=0, target=pc+4.
REQ-028 SHALL compute target = taken ? pc+imm : pc+4, modulo 2^XLEN (wrap-around, no overflow flag).
REQ-029 SHALL set mispredict = taken ^ pred_taken, including for illegal requests.
REQ-030 SHALL increment br_count on every acceptance and mis_count on every acceptance whose result mispredicts.
REQ-031 SHALL saturate both counters at 2^CNT_W-1; they SHALL never wrap.
REQ-032 SHALL give cnt_clr priority over a same-cycle increment: both counters become 0 and that cycle's event is not counted.
REQ-033 SHALL not change the handshake or result path in response to cnt_clr.

Reset
REQ-034 SHALL on rst=1 immediately force out_valid=0, taken=0, target=0, mispredict=0, illegal=0, br_count=0 and mis_count=0, independent of clk.
REQ-035 SHALL discard any in-flight result when reset is asserted mid-operation; no stale out_valid after release.
REQ-036 SHALL drive in_ready=1 while rst=1 and SHALL accept nothing until the first rising edge with rst=0.

Verification
REQ-037 SHALL cover signed/unsigned split (XLEN=32): funct3=100 and then funct3=110 with rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20 -> first taken=1, target=0x120; second taken=0, target=0x104.
REQ-038 SHALL cover back-pressure: two back-to-back requests with out_ready=0 -> first result held, in_ready=0 on cycle 2; out_ready=1 -> second request accepted in the same cycle the first is consumed.
REQ-039 SHALL cover illegal and mispredict: funct3=010, pred_taken=1 -> illegal=1, taken=0, mispredict=1, mis_count increments by 1.
REQ-040 SHALL cover wrap: funct3=000 with rs1=rs2=5, pc=0xFFFFFFF8, imm=0x10 -> target=0x00000008.
REQ-041 SHALL cover saturation and clear with CNT_W=4: 20 accepted requests -> br_count=15; cnt_clr asserted together with an acceptance -> br_count=0.
REQ-042 SHALL cover asynchronous reset: rst asserted between edges while out_valid=1 -> out_valid=0 before the next edge, all counters 0.
